// File: rtl/alu_pkg.sv
// Shared integer-op encodings and widths for the ALU issue path.
// is_alu_op() separates ops the ALU bank executes from those routed elsewhere.
package alu_pkg;

  localparam int OPTYPE_W = 4;
  localparam int TAG_W    = 6;

  localparam logic [OPTYPE_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPTYPE_W-1:0] OP_ADDI = 4'd2;
  localparam logic [OPTYPE_W-1:0] OP_LUI  = 4'd3;
  localparam logic [OPTYPE_W-1:0] OP_ORI  = 4'd4;
  localparam logic [OPTYPE_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OPTYPE_W-1:0] OP_SRAI = 4'd6;
  localparam logic [OPTYPE_W-1:0] OP_LB   = 4'd7;
  localparam logic [OPTYPE_W-1:0] OP_LW   = 4'd8;
  localparam logic [OPTYPE_W-1:0] OP_SB   = 4'd9;
  localparam logic [OPTYPE_W-1:0] OP_SW   = 4'd10;

  function automatic logic is_alu_op(input logic [OPTYPE_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SRAI);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_rr_multi_picker.sv
// N-of-M round-robin matcher: the j-th eligible requester (scanning from ptr)
// is paired with the j-th free slot (scanning upward).
module rr_multi_picker #(
  parameter int N_REQ  = 4,
  parameter int N_SLOT = 3,
  parameter int IDX_W  = 2
) (
  input  logic [N_REQ-1:0]        elig,
  input  logic [N_SLOT-1:0]       free,
  input  logic [IDX_W-1:0]        ptr,
  output logic [N_REQ-1:0]        grant,
  output logic [N_SLOT-1:0]       slot_hit,
  output logic [N_SLOT*IDX_W-1:0] slot_idx,
  output logic [IDX_W-1:0]        last_idx,
  output logic                    any_grant
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             placed;
    grant     = '0;
    slot_hit  = '0;
    slot_idx  = '0;
    last_idx  = ptr;
    any_grant = 1'b0;
    idx       = '0;
    placed    = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      idx    = IDX_W'((int'(ptr) + j) % N_REQ);
      placed = 1'b0;
      if (elig[idx]) begin
        // Once every free slot is taken, later requesters simply find no home.
        for (int k = 0; k < N_SLOT; k++) begin
          if (!placed && free[k] && !slot_hit[k]) begin
            placed                       = 1'b1;
            slot_hit[k]                  = 1'b1;
            slot_idx[k*IDX_W +: IDX_W]   = idx;
            grant[idx]                   = 1'b1;
            last_idx                     = idx;
            any_grant                    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Issues ready integer ops from the issue queue into per-ALU slots; each slot
// holds its op until the CDB accepts the result.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_ALU     = 3,
  parameter int REQ_IDX_W = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [OPTYPE_W*N_REQ-1:0]    req_optype,
  input  logic [TAG_W*N_REQ-1:0]       req_dr,
  output logic [N_REQ-1:0]             grant,
  output logic [N_ALU-1:0]             alu_number,
  output logic [OPTYPE_W*N_ALU-1:0]    alu_optype,
  output logic [TAG_W*N_ALU-1:0]       alu_dr,
  output logic [REQ_IDX_W*N_ALU-1:0]   alu_src_sel,
  input  logic [N_ALU-1:0]             wb_ready,
  output logic [1:0]                   busy_count,
  output logic                         err_illegal
);

  logic [N_ALU-1:0]           valid_q,  valid_d;
  logic [OPTYPE_W*N_ALU-1:0]  optype_q, optype_d;
  logic [TAG_W*N_ALU-1:0]     dr_q,     dr_d;
  logic [REQ_IDX_W*N_ALU-1:0] src_q,    src_d;
  logic [REQ_IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                       err_q,    err_d;

  logic [N_REQ-1:0]           legal;
  logic [N_REQ-1:0]           elig;
  logic [N_ALU-1:0]           free;
  logic [N_ALU-1:0]           slot_hit;
  logic [REQ_IDX_W*N_ALU-1:0] slot_idx;
  logic [REQ_IDX_W-1:0]       last_idx;
  logic                       any_grant;

  always_comb begin
    legal = '0;
    for (int i = 0; i < N_REQ; i++) begin
      legal[i] = is_alu_op(req_optype[i*OPTYPE_W +: OPTYPE_W]);
    end
  end

  // Gating eligibility (not grants) keeps the matcher from claiming slots
  // during reset or flush.
  assign elig = req_valid & legal & {N_REQ{rstn & ~flush}};
  assign free = ~valid_q | wb_ready;

  rr_multi_picker #(
    .N_REQ (N_REQ),
    .N_SLOT(N_ALU),
    .IDX_W (REQ_IDX_W)
  ) u_picker (
    .elig     (elig),
    .free     (free),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .slot_hit (slot_hit),
    .slot_idx (slot_idx),
    .last_idx (last_idx),
    .any_grant(any_grant)
  );

  always_comb begin
    logic [REQ_IDX_W-1:0] src;
    valid_d  = valid_q;
    optype_d = optype_q;
    dr_d     = dr_q;
    src_d    = src_q;
    src      = '0;
    for (int k = 0; k < N_ALU; k++) begin
      src = slot_idx[k*REQ_IDX_W +: REQ_IDX_W];
      if (slot_hit[k]) begin
        valid_d[k]                            = 1'b1;
        optype_d[k*OPTYPE_W +: OPTYPE_W]      = req_optype[int'(src)*OPTYPE_W +: OPTYPE_W];
        dr_d[k*TAG_W +: TAG_W]                = req_dr[int'(src)*TAG_W +: TAG_W];
        src_d[k*REQ_IDX_W +: REQ_IDX_W]       = src;
      end else if (free[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
    rr_ptr_d = any_grant ? REQ_IDX_W'((int'(last_idx) + 1) % N_REQ) : rr_ptr_q;
    err_d    = err_q | (|(req_valid & ~legal));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q  <= '0;
      optype_q <= '0;
      dr_q     <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      optype_q <= optype_d;
      dr_q     <= dr_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    busy_count = '0;
    for (int k = 0; k < N_ALU; k++) begin
      busy_count = busy_count + {1'b0, valid_q[k]};
    end
  end

  assign alu_number  = valid_q;
  assign alu_optype  = optype_q;
  assign alu_dr      = dr_q;
  assign alu_src_sel = src_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: hand-computed slot loads go into a
// queue that a negedge monitor drains whenever a slot shows a fresh op.
module tb_alu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [3:0]  req_valid;
  logic [15:0] req_optype;
  logic [23:0] req_dr;
  logic [3:0]  grant;
  logic [2:0]  alu_number;
  logic [11:0] alu_optype;
  logic [17:0] alu_dr;
  logic [5:0]  alu_src_sel;
  logic [2:0]  wb_ready;
  logic [1:0]  busy_count;
  logic        err_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  // {alu index, optype, dr, src}
  logic [13:0] exp_q[$];
  logic [2:0]  prev_free;

  always #5 clk = ~clk;

  alu_issue_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_optype (req_optype),
    .req_dr     (req_dr),
    .grant      (grant),
    .alu_number (alu_number),
    .alu_optype (alu_optype),
    .alu_dr     (alu_dr),
    .alu_src_sel(alu_src_sel),
    .wb_ready   (wb_ready),
    .busy_count (busy_count),
    .err_illegal(err_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int op, input int dr, input int src);
    exp_q.push_back({2'(k), 4'(op), 6'(dr), 2'(src)});
  endtask

  function automatic logic [15:0] ops(input int o0, input int o1, input int o2, input int o3);
    return {4'(o3), 4'(o2), 4'(o1), 4'(o0)};
  endfunction

  function automatic logic [23:0] drs(input int d0, input int d1, input int d2, input int d3);
    return {6'(d3), 6'(d2), 6'(d1), 6'(d0)};
  endfunction

  task automatic tick(input logic [3:0] exp_grant);
    @(negedge clk);
    check("grant", 32'(grant), 32'(exp_grant));
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input logic [2:0] num, input logic [1:0] busy, input logic err);
    check("alu_number", 32'(alu_number), 32'(num));
    check("busy_count", 32'(busy_count), 32'(busy));
    check("err_illegal", 32'(err_illegal), 32'(err));
  endtask

  // Monitor: a valid slot that was free last cycle holds a newly loaded op.
  always @(negedge clk) begin
    logic [13:0] e;
    logic [13:0] act;
    if (!rstn) begin
      prev_free = '1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (alu_number[k] && prev_free[k]) begin
          act = {2'(k), alu_optype[k*4 +: 4], alu_dr[k*6 +: 6], alu_src_sel[k*2 +: 2]};
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_load: got %0h expected none", act);
          end else begin
            e = exp_q.pop_front();
            check("slot_load", 32'(act), 32'(e));
          end
        end
      end
      prev_free = ~alu_number | wb_ready | {3{flush}};
    end
  end

  initial begin
    rstn       = 1'b0;
    flush      = 1'b0;
    req_valid  = 4'b1111;
    req_optype = ops(1, 2, 5, 6);
    req_dr     = drs(10, 11, 12, 13);
    wb_ready   = 3'b000;

    // Reset for two edges; grants must stay off even with legal requests.
    @(posedge clk);
    #1;
    tick(4'b0000);
    check_state(3'b000, 2'd0, 1'b0);

    rstn      = 1'b1;
    req_valid = 4'b0000;
    tick(4'b0000);
    check_state(3'b000, 2'd0, 1'b0);

    // Parallel fill from rr_ptr 0.
    req_valid  = 4'b1111;
    req_optype = ops(1, 2, 5, 6);
    req_dr     = drs(10, 11, 12, 13);
    wb_ready   = 3'b111;
    push(0, 1, 10, 0);
    push(1, 2, 11, 1);
    push(2, 5, 12, 2);
    tick(4'b0111);
    check_state(3'b111, 2'd3, 1'b0);

    // rr_ptr now 3: requester 3 first, into ALU 0.
    req_valid = 4'b1000;
    push(0, 6, 13, 3);
    tick(4'b1000);
    check_state(3'b001, 2'd1, 1'b0);

    // Fill ALUs 1 and 2 while ALU 0 is held.
    req_valid  = 4'b0111;
    req_optype = ops(3, 4, 1, 0);
    req_dr     = drs(20, 21, 22, 0);
    wb_ready   = 3'b000;
    push(1, 3, 20, 0);
    push(2, 4, 21, 1);
    tick(4'b0011);
    check_state(3'b111, 2'd3, 1'b0);

    // Backpressure: only ALU 1 drains and reloads.
    req_valid  = 4'b0001;
    req_optype = ops(1, 0, 0, 0);
    req_dr     = drs(30, 0, 0, 0);
    wb_ready   = 3'b010;
    push(1, 1, 30, 0);
    tick(4'b0001);
    check_state(3'b111, 2'd3, 1'b0);
    check("hold_dr0", 32'(alu_dr[5:0]), 32'd13);
    check("hold_op0", 32'(alu_optype[3:0]), 32'd6);
    check("hold_dr2", 32'(alu_dr[17:12]), 32'd21);
    check("hold_op2", 32'(alu_optype[11:8]), 32'd4);

    // Flush with every requester valid.
    req_valid  = 4'b1111;
    req_optype = ops(1, 2, 5, 6);
    req_dr     = drs(10, 11, 12, 13);
    wb_ready   = 3'b000;
    flush      = 1'b1;
    tick(4'b0000);
    flush     = 1'b0;
    req_valid = 4'b0000;
    check_state(3'b000, 2'd0, 1'b0);

    // rr_ptr (1) survives the flush.
    req_valid  = 4'b1111;
    req_optype = ops(1, 1, 1, 1);
    req_dr     = drs(40, 41, 42, 43);
    push(0, 1, 41, 1);
    push(1, 1, 42, 2);
    push(2, 1, 43, 3);
    tick(4'b1110);
    check_state(3'b111, 2'd3, 1'b0);

    // Fairness: one free slot per cycle, grants rotate from rr_ptr 0.
    wb_ready = 3'b001;
    for (int i = 0; i < 8; i++) begin
      push(0, 1, 40 + (i % 4), i % 4);
      tick(4'(1 << (i % 4)));
      check("fair_alu_number", 32'(alu_number), 32'h7);
    end
    req_valid = 4'b0000;
    wb_ready  = 3'b000;
    tick(4'b0000);
    check_state(3'b111, 2'd3, 1'b0);

    // Illegal op (LW) with all slots draining: no grant, sticky error.
    req_valid  = 4'b0010;
    req_optype = ops(0, 8, 0, 0);
    wb_ready   = 3'b111;
    tick(4'b0000);
    req_valid = 4'b0000;
    wb_ready  = 3'b000;
    check_state(3'b000, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000);
    end
    check_state(3'b000, 2'd0, 1'b1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Schedules ready integer ops from the issue queue onto the N_ALU parallel ALU instances.
- Picks up to N_ALU requesters per cycle (round-robin fairness) and loads each pick into a per-ALU issue slot.
- Each slot drives that ALU's one-hot select bit, optype and destination tag, and holds it until the writeback (CDB) side accepts the result.
- Sits between issue queue/reservation stations and the ALU bank; the operand datapath uses the alu_src_sel outputs.

Parameters:
- N_REQ, 4, number of issue-queue requester slots.
- N_ALU, 3, number of ALU instances (matches the 3-bit alu_number bus).
- REQ_IDX_W, 2, width of a requester index, clog2(N_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset: rstn, synchronous, active-low.
- flush  in  1  pipeline flush (mispredict); clears all slots.
- req_valid  in  N_REQ  requester i holds a ready op.
- req_optype  in  4*N_REQ  optype of requester i, bits [4i+3:4i].
- req_dr  in  6*N_REQ  physical destination tag of requester i.
- grant  out  N_REQ  combinational; bit i high means requester i is accepted this cycle and must retire its entry.
- alu_number  out  N_ALU  registered; bit k high means ALU k holds a valid op.
- alu_optype  out  4*N_ALU  registered optype per ALU.
- alu_dr  out  6*N_ALU  registered destination tag per ALU.
- alu_src_sel  out  REQ_IDX_W*N_ALU  registered index of the requester whose operands feed ALU k.
- wb_ready  in  N_ALU  CDB accepts ALU k's result this cycle.
- busy_count  out  2  number of valid slots, 0..N_ALU.
- err_illegal  out  1  sticky flag: a valid request carried an unsupported optype.

Behaviour:
- Reset (rstn=0 at posedge): all slots invalid; alu_number, alu_optype, alu_dr and alu_src_sel = 0; rr_ptr = 0; busy_count = 0; err_illegal = 0. During reset, grant = 0 combinationally.
- Supported optypes: 1 ADD, 2 ADDI, 3 LUI, 4 ORI, 5 XOR, 6 SRAI.
  - Eligible requester = req_valid high AND optype in 1..6.
  - A valid request with any other optype (0, 7..15; loads/stores go to the LSU) is never granted and sets err_illegal, which holds until reset.
- Slot k is free in cycle c if it is invalid, or if it is valid and wb_ready[k]=1. A draining slot can be refilled in the same cycle, giving one op per ALU per cycle throughput.
- Matching (combinational, cycle c):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Scan free slots in ascending k.
  - The j-th eligible requester goes to the j-th free slot.
  - Grants = min(#eligible, #free).
- At the posedge ending cycle c:
  - Matched slots load optype, dr and src index, and become valid.
  - Slots that drained without a refill become invalid.
  - Slots not free hold their contents unchanged, even if a request is waiting.
- rr_ptr update: set to (last granted index + 1) mod N_REQ; unchanged when no grant.
- Latency: grant in cycle c, then alu_number[k] high in cycle c+1.
- flush=1:
  - grant = 0 that cycle.
  - All slots become invalid at the posedge, regardless of wb_ready.
  - rr_ptr is kept.
- flush and rstn both low: reset wins.
- No slot is lost and no requester is double-granted. grant is one-hot per requester and there are at most N_ALU grant bits.
- busy_count = popcount of the registered slot valids.

Decomposition:
- Shared package alu_pkg holds:
  - the optype constants OP_ADD..OP_SRAI (1..6), OP_LB = 7, OP_LW = 8, OP_SB = 9, OP_SW = 10;
  - OPTYPE_W = 4 and TAG_W = 6;
  - function is_alu_op().
- One natural sub-module, rr_multi_picker: a parameterised N-of-M round-robin matcher producing grant bits and the per-slot requester index.

Test Plan:
- Reset, then idle:
  - Stimulus: hold rstn=0 for 2 cycles, then all req_valid=0.
  - Response: alu_number=000, busy_count=0, grant=0000, err_illegal=0.
- Parallel fill:
  - Stimulus: req_valid=1111, optypes 1,2,5,6, dr 10,11,12,13, wb_ready=111.
  - Response: grant=0111 in cycle c; in cycle c+1, alu_number=111, alu_dr = 10,11,12 on ALUs 0,1,2, alu_src_sel = 0,1,2; rr_ptr=3. Next cycle requester 3 is granted first, to ALU 0.
- Backpressure:
  - Stimulus: all slots valid, wb_ready=010, req_valid=0001 (optype 1).
  - Response: only ALU 1 reloads with src 0; ALUs 0 and 2 hold their values; grant=0001.
- Illegal op:
  - Stimulus: req_valid=0010, req_optype[1]=8 (LW).
  - Response: grant=0000, err_illegal=1 from the next cycle, still 1 after 10 idle cycles.
- Flush:
  - Stimulus: slots 111, flush=1 with req_valid=1111.
  - Response: grant=0000; next cycle alu_number=000, busy_count=0.
- Fairness:
  - Stimulus: N_ALU=3 with one slot free per cycle (wb_ready=001), all 4 requesters continuously valid.
  - Response: grants rotate 0,1,2,3,0,... with no starvation over 8 cycles.
